instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I instruction fetch front end.
// Owns the PC, keeps a single word read in flight to instruction memory, and buffers
// the returned word with its pre-split opcode/fun3/fun7 fields behind a valid/ready
// handshake. Redirects retarget the PC and any stale in-flight response is discarded.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to make a redirect with a non-zero
// target low pair set a sticky misaligned flag and park the unit in HALT until reset.
// Without it the target low bits are cleared and misaligned is tied low.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  fun3,
  output logic        fun7,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misaligned
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StValid = 3'd3;
  localparam logic [2:0] StFlush = 3'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [2:0] StHalt  = 3'd5;
`endif

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] target;
  logic        halted;

  assign target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic trap;

  assign halted     = (state_q == StHalt);
  assign trap       = redirect && !halted && (redirect_pc[1:0] != 2'b00);
  assign misaligned = mis_q;
`else
  // Low target bits are deliberately dropped in this build.
  logic unused_low;

  assign unused_low = ^redirect_pc[1:0];
  assign halted     = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Next-state, PC and instruction-buffer update; redirect outranks everything else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    if (redirect && !halted) begin
      pc_d = target;
      unique case (state_q)
        // Request just left: its response is still coming and must be dropped.
        StReq: state_d = StFlush;
        // If the outstanding response lands this very cycle it is dropped now.
        StWait, StFlush: state_d = imem_rvalid ? StReq : StFlush;
        default: state_d = StReq;
      endcase
    end else begin
      case (state_q)
        StIdle: state_d = StReq;
        StReq:  state_d = StWait;
        StWait: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            state_d = StValid;
          end
        end
        StValid: begin
          if (instr_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = StReq;
          end
        end
        StFlush: begin
          if (imem_rvalid) begin
            state_d = StReq;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        StHalt: state_d = StHalt;
`endif
        default: state_d = StIdle;
      endcase
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    if (trap) begin
      mis_d   = 1'b1;
      state_d = StHalt;
    end
`endif
  end

  // State, PC and instruction buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= Nop;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
`endif

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StValid);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign opcode      = instr_q[6:0];
  assign fun3        = instr_q[14:12];
  assign fun7        = instr_q[30];

endmodule
